elevator_ctrl: RTL and testbench

ELEVATOR_CTRL -- requirements
Module: elevator_ctrl

---
 rtl/elevator_ctrl_if.sv | 40 ++++
 rtl/elevator_ctrl.sv | 266 ++++++++++++++++++++++++++
 tb/tb_elevator_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/elevator_ctrl_if.sv
// Bus between the elevator controller and the shared floor counter / call panel.
// master: controller side; slave: counter and call-panel side.
interface elevator_ctrl_if;
    logic [15:0] call_req;
    logic [3:0]  cnt_q;
    logic        cnt_enb;
    logic [1:0]  cnt_modo;
    logic [3:0]  cnt_data;
    logic        door_open;
    logic        moving_up;
    logic        moving_down;
    logic        busy;
    logic [15:0] pending;

    modport master (
        input  call_req,
        input  cnt_q,
        output cnt_enb,
        output cnt_modo,
        output cnt_data,
        output door_open,
        output moving_up,
        output moving_down,
        output busy,
        output pending
    );

    modport slave (
        output call_req,
        output cnt_q,
        input  cnt_enb,
        input  cnt_modo,
        input  cnt_data,
        input  door_open,
        input  moving_up,
        input  moving_down,
        input  busy,
        input  pending
    );
endinterface

// File: rtl/elevator_ctrl.sv
// Elevator controller driving a shared 4-bit up/down/load floor counter.
// Optional macro ELEVATOR_ESTOP_EN adds the estop input and a HALT state.
module elevator_ctrl #(
    parameter int unsigned NUM_FLOORS    = 16,
    parameter int unsigned TRAVEL_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES   = 8
) (
    input  logic clk,
    input  logic rst,
`ifdef ELEVATOR_ESTOP_EN
    input  logic estop,
`endif
    elevator_ctrl_if.master bus
);

    localparam int unsigned FLOOR_W = 4;
    localparam int unsigned CALL_W  = 16;
    localparam int unsigned TMR_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0]   TRAVEL_LAST = TMR_W'(TRAVEL_CYCLES - 1);
    localparam logic [TMR_W-1:0]   DOOR_LAST   = TMR_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

    localparam logic [1:0] MODO_UP   = 2'b00;
    localparam logic [1:0] MODO_DOWN = 2'b01;
    localparam logic [1:0] MODO_LOAD = 2'b10;
    localparam logic [1:0] MODO_HOLD = 2'b11;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_MOVE_UP,
        S_MOVE_DOWN,
        S_CHECK,
        S_DOOR
`ifdef ELEVATOR_ESTOP_EN
        , S_HALT
`endif
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TMR_W-1:0]    r_timer;
    logic [TMR_W-1:0]    w_timer_nxt;
    logic                r_dir_up;
    logic                w_dir_up_nxt;
    logic [CALL_W-1:0]   r_pending;
    logic [CALL_W-1:0]   w_pending_nxt;

    logic [CALL_W-1:0]   w_valid_mask;
    logic [CALL_W-1:0]   w_above_mask;
    logic [CALL_W-1:0]   w_below_mask;
    logic [CALL_W-1:0]   w_here;
    logic [CALL_W-1:0]   w_calls;
    logic [CALL_W-1:0]   w_set;
    logic [CALL_W-1:0]   w_clr;
    logic                w_any;
    logic                w_above;
    logic                w_below;
    logic                w_here_pend;
    logic                w_door_recall;
    logic                w_oor;
    logic                w_travel_last;

    logic                w_cnt_enb;
    logic [1:0]          w_cnt_modo;
    logic [FLOOR_W-1:0]  w_cnt_data;
    logic                w_door_open;
    logic                w_moving_up;
    logic                w_moving_down;
    logic                w_busy;

    // Floor masks relative to the current counter value.
    always_comb begin
        w_valid_mask = '0;
        w_above_mask = '0;
        w_below_mask = '0;
        for (int unsigned i = 0; i < CALL_W; i++) begin
            w_valid_mask[i] = (i < NUM_FLOORS);
            w_above_mask[i] = (i > 32'(bus.cnt_q));
            w_below_mask[i] = (i < 32'(bus.cnt_q));
        end
        w_here        = CALL_W'(1) << bus.cnt_q;
        w_calls       = bus.call_req & w_valid_mask;
        w_any         = |r_pending;
        w_above       = |(r_pending & w_above_mask);
        w_below       = |(r_pending & w_below_mask);
        w_here_pend   = |(r_pending & w_here);
        w_door_recall = |(w_calls & w_here);
        w_oor         = (32'(bus.cnt_q) >= NUM_FLOORS);
        w_travel_last = (r_timer == TRAVEL_LAST);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_INIT;
            r_timer   <= '0;
            r_dir_up  <= 1'b1;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_timer   <= w_timer_nxt;
            r_dir_up  <= w_dir_up_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // Next state. The CHECK cycle counts as the first cycle of the next leg,
    // so floor-to-floor spacing stays TRAVEL_CYCLES while moving continuously.
    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = r_timer;
        w_dir_up_nxt = r_dir_up;
        case (r_state)
            S_INIT: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = '0;
            end
            S_IDLE: begin
                w_timer_nxt = '0;
                if (w_here_pend) begin
                    w_state_nxt = S_DOOR;
                end else if (w_any) begin
                    if (w_above && (r_dir_up || !w_below)) begin
                        w_state_nxt  = S_MOVE_UP;
                        w_dir_up_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = S_MOVE_DOWN;
                        w_dir_up_nxt = 1'b0;
                    end
                end
            end
            S_MOVE_UP, S_MOVE_DOWN: begin
                if (w_travel_last) begin
                    w_state_nxt = S_CHECK;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            S_CHECK: begin
                w_timer_nxt = TMR_W'(1);
                if (w_here_pend) begin
                    w_state_nxt = S_DOOR;
                    w_timer_nxt = '0;
                end else if (r_dir_up ? w_above : w_below) begin
                    w_state_nxt = r_dir_up ? S_MOVE_UP : S_MOVE_DOWN;
                end else if (r_dir_up ? w_below : w_above) begin
                    w_state_nxt  = r_dir_up ? S_MOVE_DOWN : S_MOVE_UP;
                    w_dir_up_nxt = !r_dir_up;
                end else begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                end
            end
            S_DOOR: begin
                if (w_door_recall) begin
                    w_timer_nxt = '0;
                end else if (r_timer == DOOR_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
`ifdef ELEVATOR_ESTOP_EN
            S_HALT: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = '0;
            end
`endif
            default: begin
                w_state_nxt = S_INIT;
                w_timer_nxt = '0;
            end
        endcase

        // A counter value outside the served range means the floor is unknown.
        if (w_oor && (r_state != S_INIT)) begin
            w_state_nxt = S_INIT;
            w_timer_nxt = '0;
        end
`ifdef ELEVATOR_ESTOP_EN
        if (estop && (r_state != S_INIT)) begin
            w_state_nxt = S_HALT;
            w_timer_nxt = '0;
        end
`endif
    end

    // Call latching; a call at the open-door floor only re-arms the door.
    always_comb begin
        w_set = w_calls;
        if (r_state == S_DOOR) begin
            w_set = w_calls & ~w_here;
        end
        w_clr = '0;
        if ((w_state_nxt == S_DOOR) && (r_state != S_DOOR)) begin
            w_clr = w_here;
        end
        w_pending_nxt = (r_pending | w_set) & ~w_clr;
    end

    // Moore outputs; reset holds everything at its idle value.
    always_comb begin
        w_cnt_enb     = 1'b0;
        w_cnt_modo    = MODO_HOLD;
        w_cnt_data    = '0;
        w_door_open   = 1'b0;
        w_moving_up   = 1'b0;
        w_moving_down = 1'b0;
        w_busy        = 1'b0;
        if (!rst) begin
            case (r_state)
                S_INIT: begin
                    w_cnt_enb  = 1'b1;
                    w_cnt_modo = MODO_LOAD;
                    w_busy     = 1'b1;
                end
                S_IDLE: begin
                    w_busy = w_any;
                end
                S_MOVE_UP: begin
                    w_moving_up = 1'b1;
                    w_busy      = 1'b1;
                    if (w_travel_last && (bus.cnt_q != TOP_FLOOR)) begin
                        w_cnt_enb  = 1'b1;
                        w_cnt_modo = MODO_UP;
                    end
                end
                S_MOVE_DOWN: begin
                    w_moving_down = 1'b1;
                    w_busy        = 1'b1;
                    if (w_travel_last && (bus.cnt_q != '0)) begin
                        w_cnt_enb  = 1'b1;
                        w_cnt_modo = MODO_DOWN;
                    end
                end
                S_CHECK: begin
                    w_moving_up   = r_dir_up;
                    w_moving_down = !r_dir_up;
                    w_busy        = 1'b1;
                end
                S_DOOR: begin
                    w_door_open = 1'b1;
                    w_busy      = 1'b1;
                end
                default: begin
                    w_busy = 1'b1;
                end
            endcase
        end
    end

    assign bus.cnt_enb     = w_cnt_enb;
    assign bus.cnt_modo    = w_cnt_modo;
    assign bus.cnt_data    = w_cnt_data;
    assign bus.door_open   = w_door_open;
    assign bus.moving_up   = w_moving_up;
    assign bus.moving_down = w_moving_down;
    assign bus.busy        = w_busy;
    assign bus.pending     = r_pending;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl with a behavioural floor counter attached.
// Define ELEVATOR_ESTOP_EN to also exercise the emergency-stop scenario.
module tb_elevator_ctrl;

    logic        clk      = 1'b0;
    logic        rst      = 1'b1;
    logic [15:0] call_req = '0;
    logic [3:0]  cnt_model = 4'd9;
`ifdef ELEVATOR_ESTOP_EN
    logic        estop    = 1'b0;
`endif
    int checks   = 0;
    int failures = 0;

    elevator_ctrl_if bus_if();

    assign bus_if.call_req = call_req;
    assign bus_if.cnt_q    = cnt_model;

    elevator_ctrl #(
        .NUM_FLOORS(16),
        .TRAVEL_CYCLES(4),
        .DOOR_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
`ifdef ELEVATOR_ESTOP_EN
        .estop(estop),
`endif
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    // Shared floor counter.
    always @(posedge clk) begin
        if (bus_if.cnt_enb) begin
            case (bus_if.cnt_modo)
                2'b00:   cnt_model <= cnt_model + 4'd1;
                2'b01:   cnt_model <= cnt_model - 4'd1;
                2'b10:   cnt_model <= bus_if.cnt_data;
                default: cnt_model <= cnt_model;
            endcase
        end
    end

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (!bus_if.busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_door(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (bus_if.door_open) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_call(input logic [15:0] bits);
        call_req = bits;
        @(negedge clk);
        call_req = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        call_req = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus_if.cnt_enb !== 1'b0) begin failures++; $display("FAIL rst_cnt_enb: got %b want 0", bus_if.cnt_enb); end
        checks++; if (bus_if.cnt_modo !== 2'b11) begin failures++; $display("FAIL rst_cnt_modo: got %b want 11", bus_if.cnt_modo); end
        checks++; if (bus_if.cnt_data !== 4'd0) begin failures++; $display("FAIL rst_cnt_data: got %0d want 0", bus_if.cnt_data); end
        checks++; if ({bus_if.door_open, bus_if.moving_up, bus_if.moving_down, bus_if.busy} !== 4'b0000) begin
            failures++; $display("FAIL rst_flags: got %b want 0000", {bus_if.door_open, bus_if.moving_up, bus_if.moving_down, bus_if.busy}); end
        checks++; if (bus_if.pending !== 16'h0000) begin failures++; $display("FAIL rst_pending: got %h want 0000", bus_if.pending); end
        rst = 1'b0;
        #1;
        checks++; if ({bus_if.cnt_enb, bus_if.cnt_modo, bus_if.cnt_data} !== {1'b1, 2'b10, 4'd0}) begin
            failures++; $display("FAIL init_load: got enb=%b modo=%b data=%0d want enb=1 modo=10 data=0", bus_if.cnt_enb, bus_if.cnt_modo, bus_if.cnt_data); end
        checks++; if (bus_if.busy !== 1'b1) begin failures++; $display("FAIL init_busy: got %b want 1", bus_if.busy); end
        @(negedge clk);
        checks++; if (bus_if.cnt_q !== 4'd0) begin failures++; $display("FAIL init_floor: got %0d want 0", bus_if.cnt_q); end
        checks++; if ({bus_if.busy, bus_if.cnt_enb, bus_if.cnt_modo} !== {1'b0, 1'b0, 2'b11}) begin
            failures++; $display("FAIL idle_after_init: got busy=%b enb=%b modo=%b want busy=0 enb=0 modo=11", bus_if.busy, bus_if.cnt_enb, bus_if.cnt_modo); end
    endtask

    task automatic test_single_call();
        int pulse_at[$];
        int down_pulses = 0;
        int door_cyc = 0;
        int door_first = -1;
        int up_cyc = 0;
        pulse_call(16'h0008);
        checks++; if (bus_if.pending !== 16'h0008) begin failures++; $display("FAIL single_pending_set: got %h want 0008", bus_if.pending); end
        for (int k = 1; k <= 30; k++) begin
            if (bus_if.cnt_enb && bus_if.cnt_modo == 2'b00) pulse_at.push_back(k);
            if (bus_if.cnt_enb && bus_if.cnt_modo == 2'b01) down_pulses++;
            if (bus_if.door_open) begin
                door_cyc++;
                if (door_first < 0) door_first = k;
            end
            if (bus_if.moving_up) up_cyc++;
            @(negedge clk);
        end
        checks++; if (pulse_at.size() != 3) begin failures++; $display("FAIL single_up_pulses: got %0d want 3", pulse_at.size()); end
        checks++; if (pulse_at.size() != 3 || pulse_at[0] != 5 || pulse_at[1] != 9 || pulse_at[2] != 13) begin
            failures++; $display("FAIL single_pulse_times: got %p want '{5,9,13}", pulse_at); end
        checks++; if (down_pulses != 0) begin failures++; $display("FAIL single_down_pulses: got %0d want 0", down_pulses); end
        checks++; if (door_cyc != 8) begin failures++; $display("FAIL single_door_len: got %0d want 8", door_cyc); end
        checks++; if (door_first != 15) begin failures++; $display("FAIL single_door_start: got %0d want 15", door_first); end
        checks++; if (up_cyc != 13) begin failures++; $display("FAIL single_moving_up_len: got %0d want 13", up_cyc); end
        checks++; if ({bus_if.cnt_q, bus_if.pending, bus_if.busy} !== {4'd3, 16'h0000, 1'b0}) begin
            failures++; $display("FAIL single_final: got floor=%0d pending=%h busy=%b want floor=3 pending=0000 busy=0", bus_if.cnt_q, bus_if.pending, bus_if.busy); end
    endtask

    task automatic test_reversal();
        int stops[$];
        bit found = 1'b0;
        bit ok;
        logic prev_door;
        pulse_call(16'h0200);
        for (int k = 0; k < 40; k++) begin
            if (bus_if.cnt_q == 4'd5 && bus_if.moving_up) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!found) begin failures++; $display("FAIL rev_reach5: got floor=%0d want 5 moving up", bus_if.cnt_q); end
        pulse_call(16'h0084);
        checks++; if (bus_if.pending !== 16'h0284) begin failures++; $display("FAIL rev_pending: got %h want 0284", bus_if.pending); end
        prev_door = bus_if.door_open;
        for (int k = 0; k < 200 && stops.size() < 3; k++) begin
            if (bus_if.door_open && !prev_door) stops.push_back(int'(bus_if.cnt_q));
            prev_door = bus_if.door_open;
            @(negedge clk);
        end
        checks++; if (stops.size() != 3 || stops[0] != 7 || stops[1] != 9 || stops[2] != 2) begin
            failures++; $display("FAIL rev_stop_order: got %p want '{7,9,2}", stops); end
        wait_idle(ok);
        checks++; if (!ok || bus_if.pending !== 16'h0000) begin
            failures++; $display("FAIL rev_idle: got idle=%0d pending=%h want idle=1 pending=0000", ok, bus_if.pending); end
    endtask

    task automatic test_door_here();
        bit ok;
        int door_cyc = 0;
        int enb_seen = 0;
        pulse_call(16'h0010);
        wait_door(ok);
        wait_idle(ok);
        checks++; if (!ok || bus_if.cnt_q !== 4'd4) begin failures++; $display("FAIL here_setup: got idle=%0d floor=%0d want idle=1 floor=4", ok, bus_if.cnt_q); end
        pulse_call(16'h0010);
        checks++; if ({bus_if.door_open, bus_if.cnt_enb} !== 2'b00) begin
            failures++; $display("FAIL here_door_early: got door=%b enb=%b want 0 0", bus_if.door_open, bus_if.cnt_enb); end
        @(negedge clk);
        checks++; if (bus_if.door_open !== 1'b1) begin failures++; $display("FAIL here_door_open: got %b want 1", bus_if.door_open); end
        checks++; if (bus_if.pending !== 16'h0000) begin failures++; $display("FAIL here_pending_clr: got %h want 0000", bus_if.pending); end
        for (int k = 2; k <= 5; k++) begin
            if (bus_if.door_open) door_cyc++;
            if (bus_if.cnt_enb) enb_seen++;
            if (k == 5) call_req = 16'h0010;
            @(negedge clk);
        end
        call_req = '0;
        checks++; if (bus_if.pending !== 16'h0000) begin failures++; $display("FAIL here_recall_pending: got %h want 0000", bus_if.pending); end
        for (int k = 6; k <= 13; k++) begin
            if (bus_if.door_open) door_cyc++;
            if (bus_if.cnt_enb) enb_seen++;
            @(negedge clk);
        end
        checks++; if (door_cyc != 12) begin failures++; $display("FAIL here_door_len: got %0d want 12", door_cyc); end
        checks++; if ({bus_if.door_open, bus_if.busy} !== 2'b00) begin
            failures++; $display("FAIL here_door_close: got door=%b busy=%b want 0 0", bus_if.door_open, bus_if.busy); end
        checks++; if (enb_seen != 0) begin failures++; $display("FAIL here_no_move: got %0d enb cycles want 0", enb_seen); end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        pulse_call(16'h0400);
        for (int k = 0; k < 40; k++) begin
            if (bus_if.cnt_q == 4'd6 && bus_if.moving_up) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!found) begin failures++; $display("FAIL rmid_reach6: got floor=%0d want 6 moving up", bus_if.cnt_q); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if ({bus_if.cnt_enb, bus_if.cnt_modo, bus_if.cnt_data} !== {1'b0, 2'b11, 4'd0}) begin
            failures++; $display("FAIL rmid_cnt: got enb=%b modo=%b data=%0d want enb=0 modo=11 data=0", bus_if.cnt_enb, bus_if.cnt_modo, bus_if.cnt_data); end
        checks++; if ({bus_if.door_open, bus_if.moving_up, bus_if.moving_down, bus_if.busy} !== 4'b0000) begin
            failures++; $display("FAIL rmid_flags: got %b want 0000", {bus_if.door_open, bus_if.moving_up, bus_if.moving_down, bus_if.busy}); end
        checks++; if (bus_if.pending !== 16'h0000) begin failures++; $display("FAIL rmid_pending: got %h want 0000", bus_if.pending); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if ({bus_if.cnt_enb, bus_if.cnt_modo} !== 3'b110) begin
            failures++; $display("FAIL rmid_init: got enb=%b modo=%b want enb=1 modo=10", bus_if.cnt_enb, bus_if.cnt_modo); end
        @(negedge clk);
        checks++; if ({bus_if.cnt_q, bus_if.busy, bus_if.pending} !== {4'd0, 1'b0, 16'h0000}) begin
            failures++; $display("FAIL rmid_reload: got floor=%0d busy=%b pending=%h want 0 0 0000", bus_if.cnt_q, bus_if.busy, bus_if.pending); end
    endtask

    task automatic test_top_floor();
        bit ok = 1'b0;
        int ups = 0;
        call_req = 16'h8000;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            call_req = '0;
            if (bus_if.cnt_enb && bus_if.cnt_modo == 2'b00) ups++;
            if (bus_if.door_open) begin
                ok = 1'b1;
                break;
            end
        end
        checks++; if (!ok || bus_if.cnt_q !== 4'd15) begin failures++; $display("FAIL top_stop: got door=%0d floor=%0d want door=1 floor=15", ok, bus_if.cnt_q); end
        checks++; if (ups != 15) begin failures++; $display("FAIL top_up_pulses: got %0d want 15", ups); end
        wait_idle(ok);
        checks++; if (!ok || bus_if.cnt_q !== 4'd15) begin failures++; $display("FAIL top_idle: got idle=%0d floor=%0d want idle=1 floor=15", ok, bus_if.cnt_q); end
    endtask

`ifdef ELEVATOR_ESTOP_EN
    task automatic test_estop();
        bit found = 1'b0;
        bit ok;
        int enb_seen = 0;
        pulse_call(16'h0040);
        for (int k = 0; k < 40; k++) begin
            if (bus_if.cnt_q == 4'd10 && bus_if.moving_down) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!found) begin failures++; $display("FAIL estop_reach10: got floor=%0d want 10 moving down", bus_if.cnt_q); end
        estop = 1'b1;
        @(negedge clk);
        checks++; if ({bus_if.door_open, bus_if.moving_up, bus_if.moving_down, bus_if.busy} !== 4'b0001) begin
            failures++; $display("FAIL estop_flags: got %b want 0001", {bus_if.door_open, bus_if.moving_up, bus_if.moving_down, bus_if.busy}); end
        for (int k = 0; k < 10; k++) begin
            if (bus_if.cnt_enb) enb_seen++;
            @(negedge clk);
        end
        checks++; if (enb_seen != 0) begin failures++; $display("FAIL estop_no_enb: got %0d want 0", enb_seen); end
        checks++; if (bus_if.pending !== 16'h0040 || bus_if.cnt_q !== 4'd10) begin
            failures++; $display("FAIL estop_hold: got pending=%h floor=%0d want 0040 10", bus_if.pending, bus_if.cnt_q); end
        estop = 1'b0;
        wait_door(ok);
        checks++; if (!ok || bus_if.cnt_q !== 4'd6) begin failures++; $display("FAIL estop_resume: got door=%0d floor=%0d want door=1 floor=6", ok, bus_if.cnt_q); end
        wait_idle(ok);
    endtask
`endif

    initial begin
        test_reset();
        test_single_call();
        test_reversal();
        test_door_here();
        test_reset_mid();
        test_top_floor();
`ifdef ELEVATOR_ESTOP_EN
        test_estop();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
